// File: rtl/btn_event_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_event_queue                                               |
// | Purpose  : Tags debounced button pulses PRESS/REPEAT and queues them in  |
// |            a show-ahead FIFO drained over a valid/ready handshake.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module btn_event_queue #(
  parameter int N_BTN       = 4,
  parameter int DEPTH       = 8,
  parameter int HOLD_WINDOW = 60000000,
  parameter int IDXW        = $clog2(N_BTN)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_BTN-1:0]             btn_pulse,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [IDXW-1:0]              ev_btn,
  output logic                         ev_repeat,
  output logic [$clog2(DEPTH+1)-1:0]   ev_count,
  output logic                         ev_dropped,
  input  logic                         clr_drop
);

  localparam int GW = $clog2(HOLD_WINDOW);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [GW-1:0] C_GAP_LOAD = GW'(HOLD_WINDOW - 1);
  localparam logic [CW-1:0] C_FULL     = CW'(DEPTH);

  logic [N_BTN-1:0][GW-1:0] r_gap;
  logic [N_BTN-1:0]         w_tag;
  logic [N_BTN-1:0]         r_pend;
  logic [N_BTN-1:0]         r_pend_rep;
  logic [N_BTN-1:0]         w_drain;
  logic [IDXW-1:0]          w_grant_idx;
  logic                     w_pop;
  logic                     w_can_push;
  logic                     w_push;
  logic                     w_merge;
  logic [IDXW:0]            r_mem [DEPTH];
  logic [IDXW:0]            w_head;
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic                     r_dropped;

  // Gap counters run independently of the FIFO so tagging ignores backpressure.
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_gap
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_gap[gi] <= '0;
      end else if (btn_pulse[gi]) begin
        r_gap[gi] <= C_GAP_LOAD;
      end else if (r_gap[gi] != '0) begin
        r_gap[gi] <= r_gap[gi] - 1'b1;
      end
    end
    assign w_tag[gi] = (r_gap[gi] != '0);
  end

  assign w_pop      = (r_count != '0) && ev_ready;
  assign w_can_push = (r_count != C_FULL) || w_pop;
  assign w_push     = (|r_pend) && w_can_push;

  // Fixed priority: scanning downward leaves the lowest pending index.
  always_comb begin
    w_grant_idx = '0;
    w_drain     = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (r_pend[i]) w_grant_idx = IDXW'(i);
    end
    w_drain[w_grant_idx] = w_push;
  end

  assign w_merge = |(btn_pulse & r_pend & ~w_drain);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= '0;
      r_pend_rep <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_pulse[i] && !(r_pend[i] && !w_drain[i])) begin
          r_pend[i]     <= 1'b1;
          r_pend_rep[i] <= w_tag[i];
        end else if (w_drain[i]) begin
          r_pend[i]     <= 1'b0;
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_pend_rep[w_grant_idx], w_grant_idx};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_dropped <= 1'b0;
    else if (w_merge)  r_dropped <= 1'b1;
    else if (clr_drop) r_dropped <= 1'b0;
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign ev_valid   = (r_count != '0);
  assign ev_btn     = ev_valid ? w_head[IDXW-1:0] : '0;
  assign ev_repeat  = ev_valid ? w_head[IDXW] : 1'b0;
  assign ev_count   = r_count;
  assign ev_dropped = r_dropped;

endmodule
`default_nettype wire
